// File: rtl/irq_mode_ctrl.sv
// irq_mode_ctrl: drives the processor Mode, latches and arbitrates edge interrupts,
// and sequences pipeline flush, vector redirect and return-from-interrupt.
`default_nettype none

module irq_mode_ctrl #(
    parameter int unsigned NUM_IRQ    = 4,
    parameter int unsigned PC_WIDTH   = 16,
    parameter int unsigned VEC_BASE   = 16'h0010,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic [NUM_IRQ-1:0]  irq_mask,
    input  logic                int_en,
    input  logic [PC_WIDTH-1:0] pc_in,
    input  logic                flush_done,
    input  logic                reti,
    output logic [1:0]          Mode,
    output logic                flush_req,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic [NUM_IRQ-1:0]  irq_ack
);

    localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [2:0] {
        S_BOOT    = 3'd0,
        S_USER    = 3'd1,
        S_FLUSH   = 3'd2,
        S_ENTER   = 3'd3,
        S_HANDLER = 3'd4,
        S_RETURN  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_IRQ-1:0]  irq_prev_q;
    logic [NUM_IRQ-1:0]  pending_q, pending_d;
    logic [NUM_IRQ-1:0]  pend_clr;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PC_WIDTH-1:0] ret_pc_q, ret_pc_d;
    logic                redirect_valid_q, redirect_valid_d;
    logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic [NUM_IRQ-1:0]  irq_ack_q, irq_ack_d;

    logic [NUM_IRQ-1:0]  rise;
    logic [NUM_IRQ-1:0]  cand;
    logic [IDX_W-1:0]    win_idx;
    logic [PC_WIDTH-1:0] vec_pc;

    assign rise   = irq & ~irq_prev_q;
    assign cand   = pending_q & irq_mask;
    assign vec_pc = PC_WIDTH'(VEC_BASE + VEC_STRIDE * 32'(idx_q));

    // Descending scan so the lowest set index is the last (winning) assignment.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        ret_pc_d         = ret_pc_q;
        pend_clr         = '0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        irq_ack_d        = '0;

        case (state_q)
            S_BOOT: begin
                state_d = S_USER;
            end
            S_USER: begin
                if (int_en && (cand != '0)) begin
                    state_d = S_FLUSH;
                    idx_d   = win_idx;
                end
            end
            S_FLUSH: begin
                // Redirect and ack are prepared here so they appear registered in ENTER.
                if (flush_done) begin
                    state_d          = S_ENTER;
                    ret_pc_d         = pc_in;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = vec_pc;
                    irq_ack_d        = NUM_IRQ'(1) << idx_q;
                end
            end
            S_ENTER: begin
                pend_clr = NUM_IRQ'(1) << idx_q;
                state_d  = S_HANDLER;
            end
            S_HANDLER: begin
                if (reti) begin
                    state_d          = S_RETURN;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = ret_pc_q;
                end
            end
            S_RETURN: begin
                state_d = S_USER;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        pending_d = (pending_q & ~pend_clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_BOOT;
            irq_prev_q       <= '0;
            pending_q        <= '0;
            idx_q            <= '0;
            ret_pc_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            irq_ack_q        <= '0;
        end else begin
            state_q          <= state_d;
            irq_prev_q       <= irq;
            pending_q        <= pending_d;
            idx_q            <= idx_d;
            ret_pc_q         <= ret_pc_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            irq_ack_q        <= irq_ack_d;
        end
    end

    always_comb begin
        case (state_q)
            S_BOOT:           Mode = 2'b00;
            S_USER, S_FLUSH:  Mode = 2'b01;
            default:          Mode = 2'b10;
        endcase
    end

    assign flush_req      = (state_q == S_FLUSH);
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign irq_ack        = irq_ack_q;

endmodule

`default_nettype wire
